reg_file_sb: RTL

Parametrised integer register file for the ID stage with NRD combinational read ports, two write ports (ALU writeback and load return), a per-register busy scoreboard for hazard detection, and a hardware clear sequencer that zeroes the array without a reset pulse. It sits between decode (read/issue) and writeback, and is the next-generation replacement of the single-write-port register file.

---
 rtl/reg_file_sb.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: ID-stage register file, NRD read ports, ALU + load write ports, busy scoreboard, clear sequencer
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   rd_sel/rd_data       packed read selects (AW each) and read data (XLEN each)
//   rd_busy              scoreboard bit of each selected register
//   wb_en/wb_sel/wb_data ALU writeback port
//   ld_en/ld_sel/ld_data load-return port, wins over wb on the same register
//   iss_en/iss_sel       issue marks the destination busy
//   clear_req            one-cycle request to zero the array
//   clear_busy           high while the sweep runs
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_sel,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_sel,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_sel,
  input  logic              clear_req,
  output logic              clear_busy
);
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam logic [NREGS-1:0] nz_mask = ~{{(NREGS-1){1'b0}}, 1'b1};
  state_t state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nx, wb_hit, ld_hit, iss_hit;
  logic sweep, last;
  assign sweep = state == SWEEP;
  assign last = idx == AW'(NREGS - 1);
  assign clear_busy = sweep;
  // one-hot write/issue decodes; register 0 is masked out so it is never written or marked busy
  assign wb_hit = ({{(NREGS-1){1'b0}}, wb_en} << wb_sel) & nz_mask;
  assign ld_hit = ({{(NREGS-1){1'b0}}, ld_en} << ld_sel) & nz_mask;
  assign iss_hit = ({{(NREGS-1){1'b0}}, iss_en} << iss_sel) & nz_mask;
  // issue beats a same-edge completion because it belongs to the newer instruction
  assign busy_nx = sweep ? busy : clear_req ? '0 : (busy & ~(wb_hit | ld_hit)) | iss_hit;
  always_comb begin
    state_nx = sweep ? (last ? IDLE : SWEEP) : (clear_req ? SWEEP : IDLE);
    idx_nx = sweep ? (last ? idx : idx + 1'b1) : (clear_req ? AW'(1) : idx);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      busy <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      busy <= busy_nx;
      for (int i = 1; i < NREGS; i++) begin
        if (sweep) begin
          if (idx == AW'(i)) regs[i] <= '0;
        end else if (ld_hit[i]) regs[i] <= ld_data;
        else if (wb_hit[i]) regs[i] <= wb_data;
      end
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] s;
    logic [XLEN-1:0] stored;
    assign s = rd_sel[k*AW +: AW];
    assign stored = s == '0 ? '0 : regs[s];
`ifdef REGFILE_BYPASS_EN
    logic ld_fwd, wb_fwd;
    // forwarding is suppressed during the sweep because those writes are dropped
    assign ld_fwd = !sweep && ld_hit[s];
    assign wb_fwd = !sweep && wb_hit[s];
    assign rd_data[k*XLEN +: XLEN] = ld_fwd ? ld_data : wb_fwd ? wb_data : stored;
    assign rd_busy[k] = busy[s] && !ld_fwd && !wb_fwd;
`else
    assign rd_data[k*XLEN +: XLEN] = stored;
    assign rd_busy[k] = busy[s];
`endif
  end
endmodule
